// File: rtl/recip_pkg.sv
// -----------------------------------------------------------------------------
// recip_pkg
// Shared definitions for the sequential fixed-point reciprocal:
//   - FSM state encoding (IDLE, CALC, DONE)
//   - helpers that derive the divider geometry from the Q-format parameters
//   - helpers that derive the signed saturation limits from the output width
// No ports; imported by reciprocal_qfmt_seq.
// -----------------------------------------------------------------------------
package recip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Quotient bits produced (= number of divide steps). The numerator is
    // 1 << (in_frac + out_frac), so the quotient is at most that value and
    // needs one bit more than the shift amount.
    function automatic int calc_num_w(input int in_frac, input int out_frac);
        return in_frac + out_frac + 1;
    endfunction

    // Width of a down-counter that starts at num_w-1 and stops at 0.
    function automatic int calc_cnt_w(input int num_w);
        return (num_w > 1) ? $clog2(num_w) : 1;
    endfunction

    // Width used to compare the quotient magnitude against the output limits
    // without truncating either side.
    function automatic int calc_cmp_w(input int num_w, input int out_w);
        return ((num_w > out_w) ? num_w : out_w) + 1;
    endfunction

    // Largest magnitude representable for a negative result: 2^(out_w-1).
    // The positive limit is one less than this.
    function automatic int neg_lim_shift(input int out_w);
        return out_w - 1;
    endfunction

endpackage : recip_pkg

// File: rtl/recip_divstep.sv
// -----------------------------------------------------------------------------
// recip_divstep
// One combinational radix-2 restoring division step.
//   rem_in   in   W   partial remainder, always < divisor
//   num_bit  in   1   next numerator bit (MSB first)
//   divisor  in   W   divisor magnitude
//   rem_out  out  W   updated partial remainder
//   qbit     out  1   quotient bit produced by this step
// -----------------------------------------------------------------------------
module recip_divstep #(
    parameter int W = 33
) (
    input  logic [W-1:0] rem_in,
    input  logic         num_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         qbit
);

    logic [W:0] rem_sh;
    logic [W:0] diff;

    // Because rem_in < divisor, the shifted remainder is below 2*divisor, so
    // after subtracting the divisor bit W of the difference is exactly the
    // borrow: it is clear precisely when rem_sh >= divisor.
    // NOTE: every signal written in always_comb gets a value on every path;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        rem_sh  = {rem_in, num_bit};
        diff    = rem_sh - {1'b0, divisor};
        qbit    = ~diff[W];
        rem_out = qbit ? diff[W-1:0] : rem_sh[W-1:0];
    end

endmodule : recip_divstep

// File: rtl/reciprocal_qfmt_seq.sv
// -----------------------------------------------------------------------------
// reciprocal_qfmt_seq
// Sequential signed fixed-point reciprocal, inv_out = 1/d_in, truncated toward
// zero and saturated to the output range. One request in flight at a time.
//   clk        in   1       clock, rising edge
//   reset_n    in   1       asynchronous reset, active-low
//   in_valid   in   1       d_in / in_tag valid
//   in_ready   out  1       request can be accepted (IDLE only)
//   d_in       in   IN_W    divisor, signed Q(IN_W-IN_FRAC).IN_FRAC
//   in_tag     in   TAG_W   request tag
//   out_valid  out  1       result valid, held until out_ready
//   out_ready  in   1       consumer accepts result
//   inv_out    out  OUT_W   reciprocal, signed Q(OUT_W-OUT_FRAC).OUT_FRAC
//   out_tag    out  TAG_W   tag of the request that produced inv_out
//   error      out  1       divisor was zero
//   sat        out  1       true quotient exceeded the output range
// -----------------------------------------------------------------------------
module reciprocal_qfmt_seq
    import recip_pkg::*;
#(
    parameter int IN_W     = 32,
    parameter int IN_FRAC  = 28,
    parameter int OUT_W    = 32,
    parameter int OUT_FRAC = 16,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  d_in,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] inv_out,
    output logic [TAG_W-1:0] out_tag,
    output logic             error,
    output logic             sat
);

    localparam int NUM_W = calc_num_w(IN_FRAC, OUT_FRAC);
    localparam int REM_W = IN_W + 1;
    localparam int CNT_W = calc_cnt_w(NUM_W);
    localparam int CMP_W = calc_cmp_w(NUM_W, OUT_W);

    localparam logic [NUM_W-1:0] NUM     = {1'b1, {(NUM_W-1){1'b0}}};
    localparam logic [CMP_W-1:0] NEG_LIM = CMP_W'(1) << neg_lim_shift(OUT_W);
    localparam logic [CMP_W-1:0] POS_LIM = NEG_LIM - CMP_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NUM_W - 1);

    state_t             state;
    logic               sign_q;
    logic [REM_W-1:0]   div_q;
    logic [REM_W-1:0]   rem_q;
    logic [NUM_W-1:0]   num_sr;
    logic [NUM_W-2:0]   quot_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TAG_W-1:0]   tag_q;

    logic [REM_W-1:0]   d_ext;
    logic [REM_W-1:0]   d_mag;
    logic [REM_W-1:0]   rem_nxt;
    logic               qbit;
    logic [NUM_W-1:0]   quot_nxt;
    logic [CMP_W-1:0]   q_ext;
    logic               sat_pos;
    logic               sat_neg;
    logic [OUT_W-1:0]   res_pos;
    logic [OUT_W-1:0]   res_neg;

    // |d| is one bit wider than d_in so that -2^(IN_W-1) has a magnitude.
    always_comb begin
        d_ext = {d_in[IN_W-1], d_in};
        d_mag = d_in[IN_W-1] ? -d_ext : d_ext;
    end

    recip_divstep #(
        .W (REM_W)
    ) u_divstep (
        .rem_in  (rem_q),
        .num_bit (num_sr[NUM_W-1]),
        .divisor (div_q),
        .rem_out (rem_nxt),
        .qbit    (qbit)
    );

    // Output stage works on the quotient including the bit being produced this
    // cycle, so the result is registered on the same edge as the last step.
    always_comb begin
        quot_nxt = {quot_q, qbit};
        q_ext    = CMP_W'(quot_nxt);
        sat_pos  = q_ext > POS_LIM;
        sat_neg  = q_ext > NEG_LIM;
        res_pos  = sat_pos ? POS_LIM[OUT_W-1:0] : q_ext[OUT_W-1:0];
        // A magnitude of exactly 2^(OUT_W-1) negates to the most negative code.
        res_neg  = sat_neg ? NEG_LIM[OUT_W-1:0] : -q_ext[OUT_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            inv_out   <= '0;
            out_tag   <= '0;
            error     <= 1'b0;
            sat       <= 1'b0;
            sign_q    <= 1'b0;
            div_q     <= '0;
            rem_q     <= '0;
            num_sr    <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            tag_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // in_ready rises on the first edge after reset release.
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sign_q   <= d_in[IN_W-1];
                        div_q    <= d_mag;
                        tag_q    <= in_tag;
                        rem_q    <= '0;
                        num_sr   <= NUM;
                        quot_q   <= '0;
                        cnt_q    <= CNT_INIT;
                        if (d_in == '0) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            inv_out   <= '0;
                            out_tag   <= in_tag;
                            error     <= 1'b1;
                            sat       <= 1'b0;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end

                ST_CALC: begin
                    rem_q  <= rem_nxt;
                    quot_q <= quot_nxt[NUM_W-2:0];
                    num_sr <= num_sr << 1;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        inv_out   <= sign_q ? res_neg : res_pos;
                        sat       <= sign_q ? sat_neg : sat_pos;
                        error     <= 1'b0;
                        out_tag   <= tag_q;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : reciprocal_qfmt_seq
